// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: major opcodes, the funct3 codes that select
// a shift-immediate, and the format codes reported by the immediate stage.
package riscv_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

    localparam int FMT_W = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_NONE = 3'd7
    } fmt_e;

endpackage

// File: rtl/imm_format_decode.sv
// Combinational RISC-V immediate extractor.
// Ports:
//   instr   - raw 32-bit instruction word
//   imm     - immediate, sign-extended (zero-extended for shift amounts)
//   fmt     - format code (fmt_e encoding)
//   illegal - opcode not recognised
module imm_format_decode
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    output logic [DATA_WIDTH-1:0] imm,
    output logic [FMT_W-1:0]      fmt,
    output logic                  illegal
);

    logic signed [31:0] imm32;
    logic [5:0]         shamt;
    fmt_e               fmt_d;
    logic [2:0]         funct3;

    assign funct3 = instr[14:12];

    always_comb begin
        imm32   = '0;
        fmt_d   = FMT_NONE;
        illegal = 1'b0;
        // RV64 shift amounts carry one extra bit
        shamt   = (DATA_WIDTH == 64) ? instr[25:20] : {1'b0, instr[24:20]};
        case (instr[6:0])
            OP_IMM: begin
                if (funct3 == F3_SLLI || funct3 == F3_SRXI) begin
                    fmt_d = FMT_SH;
                end else begin
                    fmt_d = FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                fmt_d = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                fmt_d = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt_d = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt_d = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt_d = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
            end
            OP_REG: begin
                fmt_d = FMT_R;
            end
            default: begin
                fmt_d   = FMT_NONE;
                illegal = 1'b1;
            end
        endcase

        // signed cast widens with sign extension when DATA_WIDTH is 64
        if (fmt_d == FMT_SH) begin
            imm = DATA_WIDTH'(shamt);
        end else begin
            imm = DATA_WIDTH'(imm32);
        end
    end

    assign fmt = fmt_d;

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decodes each accepted instruction and
// holds the result in a 2-entry skid FIFO with registered outputs.
// Ports:
//   clk, rstn (sync, active-low), flush (sync)
//   in_valid/in_ready/in_instr/in_tag     - upstream handshake
//   out_valid/out_ready                   - downstream handshake
//   out_imm/out_fmt/out_illegal/out_tag   - head entry contents
module imm_gen_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [FMT_W-1:0]      out_fmt,
    output logic                  out_illegal,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    logic [DATA_WIDTH-1:0] dec_imm;
    logic [FMT_W-1:0]      dec_fmt;
    logic                  dec_illegal;

    imm_format_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    logic [DATA_WIDTH-1:0] mem_imm [2];
    logic [FMT_W-1:0]      mem_fmt [2];
    logic                  mem_ill [2];
    logic [TAG_WIDTH-1:0]  mem_tag [2];
    logic [1:0]            count;
    logic                  wptr;
    logic                  rptr;
    logic                  push;
    logic                  pop;

    // in_ready depends only on count, so out_ready never reaches upstream
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_imm[i] <= '0;
                mem_fmt[i] <= '0;
                mem_ill[i] <= 1'b0;
                mem_tag[i] <= '0;
            end
        end else if (flush) begin
            // realign pointers so the next push lands at the read slot
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else begin
            if (push) begin
                mem_imm[wptr] <= dec_imm;
                mem_fmt[wptr] <= dec_fmt;
                mem_ill[wptr] <= dec_illegal;
                mem_tag[wptr] <= in_tag;
                wptr          <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_imm     = mem_imm[rptr];
    assign out_fmt     = mem_fmt[rptr];
    assign out_illegal = mem_ill[rptr];
    assign out_tag     = mem_tag[rptr];

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_tag = '0;
    logic        out_ready = 1'b0;

    logic        r32_in_ready, r32_out_valid, r32_ill;
    logic [31:0] r32_imm, r32_tag;
    logic [2:0]  r32_fmt;
    logic        r64_in_ready, r64_out_valid, r64_ill;
    logic [63:0] r64_imm;
    logic [31:0] r64_tag;
    logic [2:0]  r64_fmt;

    always #5 clk = ~clk;

    imm_gen_stage #(.DATA_WIDTH(32), .TAG_WIDTH(32)) dut32 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(r32_in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(r32_out_valid), .out_ready(out_ready), .out_imm(r32_imm),
        .out_fmt(r32_fmt), .out_illegal(r32_ill), .out_tag(r32_tag)
    );

    imm_gen_stage #(.DATA_WIDTH(64), .TAG_WIDTH(32)) dut64 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(r64_in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(r64_out_valid), .out_ready(out_ready), .out_imm(r64_imm),
        .out_fmt(r64_fmt), .out_illegal(r64_ill), .out_tag(r64_tag)
    );

    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    ent_t mq[$];
    int   tests = 0;
    int   fails = 0;
    bit   rst_seen = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference immediate: the field value read as a signed integer, then
    // truncated to the datapath width.
    function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] tg);
        ent_t   e;
        longint v = 0;
        longint sh32 = 0;
        longint sh64 = 0;
        bit     is_sh = 0;
        e.ill = 1'b0;
        e.tag = tg;
        case (ins[6:0])
            7'h13: begin
                if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) begin
                    is_sh = 1; e.fmt = 3'd6;
                    sh32 = longint'(ins[24:20]);
                    sh64 = longint'(ins[25:20]);
                end else begin
                    e.fmt = 3'd1; v = longint'($signed(ins[31:20]));
                end
            end
            7'h03, 7'h67, 7'h73: begin e.fmt = 3'd1; v = longint'($signed(ins[31:20])); end
            7'h23: begin e.fmt = 3'd2; v = longint'($signed({ins[31:25], ins[11:7]})); end
            7'h63: begin
                e.fmt = 3'd3;
                v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'h37, 7'h17: begin e.fmt = 3'd4; v = longint'($signed({ins[31:12], 12'h000})); end
            7'h6F: begin
                e.fmt = 3'd5;
                v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'h33: begin e.fmt = 3'd0; v = 0; end
            default: begin e.fmt = 3'd7; e.ill = 1'b1; v = 0; end
        endcase
        if (is_sh) begin
            e.imm32 = 32'(sh32);
            e.imm64 = 64'(sh64);
        end else begin
            e.imm32 = 32'(v);
            e.imm64 = 64'(v);
        end
        return e;
    endfunction

    task automatic check_state();
        bit   nonempty;
        ent_t h;
        nonempty = (mq.size() != 0);
        chk("in_ready32",  64'(r32_in_ready),  64'(mq.size() != 2));
        chk("in_ready64",  64'(r64_in_ready),  64'(mq.size() != 2));
        chk("out_valid32", 64'(r32_out_valid), 64'(nonempty));
        chk("out_valid64", 64'(r64_out_valid), 64'(nonempty));
        if (nonempty) begin
            h = mq[0];
            chk("imm32",  64'(r32_imm), 64'(h.imm32));
            chk("imm64",  r64_imm,      h.imm64);
            chk("fmt32",  64'(r32_fmt), 64'(h.fmt));
            chk("fmt64",  64'(r64_fmt), 64'(h.fmt));
            chk("ill32",  64'(r32_ill), 64'(h.ill));
            chk("ill64",  64'(r64_ill), 64'(h.ill));
            chk("tag32",  64'(r32_tag), 64'(h.tag));
            chk("tag64",  64'(r64_tag), 64'(h.tag));
        end else if (rst_seen) begin
            chk("rst_zero32", {31'b0, r32_ill, r32_fmt, r32_imm} | 64'(r32_tag), 64'd0);
            chk("rst_zero64", r64_imm | 64'(r64_fmt) | 64'(r64_ill) | 64'(r64_tag), 64'd0);
        end
    endtask

    // One clock: drive at the falling edge, advance the model at the rising
    // edge, compare at the next falling edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                        input logic ordy, input logic fl, input logic rs);
        bit push, pop;
        in_valid = v; in_instr = ins; in_tag = tg;
        out_ready = ordy; flush = fl; rstn = rs;
        push = v && (mq.size() != 2);
        pop  = (mq.size() != 0) && ordy;
        @(posedge clk);
        if (!rs) begin
            mq.delete();
            rst_seen = 1'b1;
        end else if (fl) begin
            mq.delete();
        end else begin
            rst_seen = 1'b0;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(ref_decode(ins, tg));
        end
        @(negedge clk);
        check_state();
    endtask

    localparam logic [31:0] ADDI = 32'hFFF00093;

    initial begin
        vec_t        vt [10];
        logic [6:0]  ops [10];
        logic [31:0] ins;

        vt[0] = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
        vt[1] = '{32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0};
        vt[2] = '{32'h123450B7, 32'h12345000, 64'h00000000_12345000, 3'd4, 1'b0};
        vt[3] = '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF_80000000, 3'd4, 1'b0};
        vt[4] = '{32'h4030D093, 32'h00000003, 64'h00000000_00000003, 3'd6, 1'b0};
        vt[5] = '{32'h0000007F, 32'h00000000, 64'h00000000_00000000, 3'd7, 1'b1};
        vt[6] = '{32'h002081B3, 32'h00000000, 64'h00000000_00000000, 3'd0, 1'b0};
        vt[7] = '{32'hFE20AC23, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 3'd2, 1'b0};
        vt[8] = '{32'h0080006F, 32'h00000008, 64'h00000000_00000008, 3'd5, 1'b0};
        vt[9] = '{32'h02109093, 32'h00000001, 64'h00000000_00000021, 3'd6, 1'b0};

        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

        @(negedge clk);
        step(0, 32'h0, 32'h0, 0, 0, 0);
        step(1, ADDI, 32'h55, 1, 1, 0);

        // single-instruction decode, one-cycle latency from an empty FIFO
        for (int i = 0; i < 10; i++) begin
            step(1, vt[i].instr, 32'(100 + i), 1, 0, 1);
            chk("tv_valid", 64'(r32_out_valid & r64_out_valid), 64'd1);
            chk("tv_imm32", 64'(r32_imm), 64'(vt[i].imm32));
            chk("tv_imm64", r64_imm, vt[i].imm64);
            chk("tv_fmt32", 64'(r32_fmt), 64'(vt[i].fmt));
            chk("tv_fmt64", 64'(r64_fmt), 64'(vt[i].fmt));
            chk("tv_ill32", 64'(r32_ill), 64'(vt[i].ill));
            chk("tv_tag32", 64'(r32_tag), 64'(100 + i));
            step(0, 32'h0, 32'h0, 1, 0, 1);
        end

        // backpressure: tags 1,2 accepted, 3 held until space opens
        step(1, ADDI, 32'd1, 0, 0, 1);
        chk("bp_ready1", 64'(r32_in_ready), 64'd1);
        step(1, ADDI, 32'd2, 0, 0, 1);
        chk("bp_ready2", 64'(r32_in_ready), 64'd0);
        step(1, ADDI, 32'd3, 0, 0, 1);
        chk("bp_head1", 64'(r32_tag), 64'd1);
        step(1, ADDI, 32'd3, 1, 0, 1);
        chk("bp_head2", 64'(r32_tag), 64'd2);
        step(1, ADDI, 32'd3, 1, 0, 1);
        chk("bp_head3", 64'(r32_tag), 64'd3);
        step(0, 32'h0, 32'h0, 1, 0, 1);
        chk("bp_empty", 64'(r32_out_valid), 64'd0);

        // flush with two held entries and a simultaneous push
        step(1, 32'h0000007F, 32'hA1, 0, 0, 1);
        step(1, ADDI, 32'hA2, 0, 0, 1);
        step(1, ADDI, 32'hBAD, 1, 1, 1);
        chk("fl_valid", 64'(r32_out_valid | r64_out_valid), 64'd0);
        chk("fl_ready", 64'(r32_in_ready & r64_in_ready), 64'd1);
        step(0, 32'h0, 32'h0, 1, 0, 1);
        step(1, vt[2].instr, 32'hC0, 0, 0, 1);
        chk("fl_next_tag", 64'(r32_tag), 64'hC0);

        // reset mid-stream with a full FIFO
        step(1, ADDI, 32'hC1, 0, 0, 1);
        chk("rs_full", 64'(r32_in_ready), 64'd0);
        step(1, ADDI, 32'hC2, 1, 1, 0);
        chk("rs_valid", 64'(r32_out_valid), 64'd0);
        chk("rs_imm64", r64_imm, 64'd0);
        step(1, vt[3].instr, 32'hD0, 0, 0, 1);
        chk("rs_resume", r64_imm, 64'hFFFFFFFF_80000000);
        step(0, 32'h0, 32'h0, 1, 0, 1);

        // randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) < 8) ins[6:0] = ops[$urandom_range(0, 9)];
            step(1'($urandom_range(0, 1)), ins, $urandom,
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 63) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, immediate/datapath width; legal values 32 and 64.
REQ-002 Parameter TAG_WIDTH, default 32, width of the opaque sideband (PC) carried with each instruction.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  synchronous pipeline flush.
REQ-006 in_valid  input  1  upstream holds a valid instruction.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 in_instr  input  32  raw RISC-V instruction word.
REQ-009 in_tag  input  TAG_WIDTH  sideband travelling with the instruction.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  downstream accepts the head entry.
REQ-012 out_imm  output  DATA_WIDTH  sign- or zero-extended immediate.
REQ-013 out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, SH=6, NONE=7.
REQ-014 out_illegal  output  1  opcode not recognised.
REQ-015 out_tag  output  TAG_WIDTH  sideband of the head entry.

Function
REQ-016 Opcode decode: 0010011/0000011/1100111/1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011 -> R; all others -> NONE with illegal=1.
REQ-017 Opcode 0010011 with funct3 001 or 101 -> SH, imm = shamt zero-extended; shamt = instr[24:20] for DATA_WIDTH 32, instr[25:20] for 64.
REQ-018 I/S/B/J immediates use standard RV bit placement (B/J bit0 = 0), sign-extended from instr[31] to DATA_WIDTH.
REQ-019 U imm = {instr[31:12], 12'b0}, sign-extended from bit 31 to DATA_WIDTH.
REQ-020 R and NONE formats: imm = 0.
REQ-021 Decoded results are stored in a 2-entry FIFO (skid buffer) with an occupancy count of 0..2.
REQ-022 in_ready = (count != 2); it is a function of registered state only, with no combinational path from out_ready.
REQ-023 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-024 Latency: an instruction pushed at edge N is visible at the outputs after edge N when the FIFO is empty, with no combinational in->out path.
REQ-025 Push and pop in the same cycle leave count unchanged and preserve ordering.
REQ-026 out_valid = (count != 0); out_* are held stable while out_valid && !out_ready.
REQ-027 Write and read pointers are 1 bit each and wrap modulo 2.
REQ-028 flush: next edge sets count=0 and out_valid=0; a simultaneous push is dropped and a simultaneous pop has no further effect.

Reset
REQ-029 While rstn=0 at an edge: count=0, pointers=0, all entries cleared; outputs then read out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
REQ-030 Reset overrides flush and any handshake in the same cycle; an in-flight instruction is discarded.

Structure
REQ-031 Opcode constants, funct3 shift codes and the format-code encoding shall reside in shared package riscv_pkg.
REQ-032 Combinational decode shall be a sub-module imm_format_decode (instr in; imm, fmt, illegal out; DATA_WIDTH parameter); imm_gen_stage holds only the FIFO and control.

Verification
REQ-033 DW=32, push 0xFFF00093 (addi -1) -> one cycle later out_imm=0xFFFFFFFF, fmt=1, illegal=0.
REQ-034 DW=32, push 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC, fmt=3; push 0x123450B7 (lui) -> out_imm=0x12345000, fmt=4.
REQ-035 DW=64, push 0x800000B7 -> out_imm=0xFFFFFFFF80000000; push 0x4030D093 (srai 3) -> out_imm=0x3, fmt=6.
REQ-036 out_ready=0, in_valid held with tags 1,2,3 -> tags 1 and 2 accepted, in_ready=0 after the second push, tag 3 held; out_ready=1 -> outputs 1,2,3 in order, with no loss or duplication.
REQ-037 Push 0x0000007F -> out_illegal=1, fmt=7, imm=0; with 2 entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the pushed instruction never appears.
REQ-038 Assert rstn=0 mid-stream with count=2 -> next cycle out_valid=0 and all outputs zero; normal operation resumes on the first cycle after rstn=1.
